instruction_fetch: RTL and testbench

Instruction fetch/decode front end for the MiniAlu-style core. It sequences the program counter, drives the address into the combinational program ROM and registers the returned 28-bit instruction. It splits that instruction into decoded fields for the execute stage. It resolves `JMP` locally, resolves `BLE` using a condition returned by execute, and implements the `NOP` delay count.

---
 rtl/instruction_fetch_if.sv | 25 ++
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, execute back-pressure and branch
// condition, and the decoded instruction presented to execute.
interface instruction_fetch_if;
  logic [15:0] address;
  logic [27:0] instruction;
  logic        stall;
  logic        branch_taken;
  logic        valid;
  logic [3:0]  operation;
  logic [7:0]  destination;
  logic [7:0]  source1;
  logic [7:0]  source0;
  logic [15:0] immediate;
  logic [15:0] pc;

  modport master (
    output address, valid, operation, destination, source1, source0, immediate, pc,
    input  instruction, stall, branch_taken
  );

  modport slave (
    input  address, valid, operation, destination, source1, source0, immediate, pc,
    output instruction, stall, branch_taken
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch/decode front end: PC sequencing, instruction register,
// local JMP, BLE resolution from execute, and NOP delay count.
//
// state  | meaning
// RUN    | fetch and present one instruction per cycle
// WAIT   | NOP delay; bubbles until the down-counter reaches terminal count
// BRANCH | BLE presented; resolve with branch_taken, one bubble
module instruction_fetch #(
  parameter logic [15:0] PC_RESET = 16'd0
) (
  input logic          clk,
  input logic          rst,
  instruction_fetch_if.master bus
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_BLE = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd6;

  typedef enum logic [1:0] {RUN, WAIT, BRANCH} state_t;

  state_t      state_q, state_d;
  logic [15:0] address_q, address_d;
  logic [27:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [23:0] count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      address_q <= PC_RESET;
      ir_q      <= 28'd0;
      pc_q      <= 16'd0;
      valid_q   <= 1'b0;
      count_q   <= 24'd0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    count_d   = count_q;
    // A stall freezes every register, including a pending BLE resolution.
    if (!bus.stall) begin
      case (state_q)
        RUN: begin
          ir_d      = bus.instruction;
          pc_d      = address_q;
          valid_d   = 1'b1;
          address_d = address_q + 16'd1;
          case (bus.instruction[27:24])
            OP_JMP: address_d = {8'd0, bus.instruction[23:16]};
            OP_NOP: begin
              if (bus.instruction[23:0] != 24'd0) begin
                count_d = bus.instruction[23:0];
                state_d = WAIT;
              end
            end
            OP_BLE:  state_d = BRANCH;
            default: ;
          endcase
        end
        WAIT: begin
          valid_d = 1'b0;
          count_d = count_q - 24'd1;
          if (count_q == 24'd1) state_d = RUN;
        end
        BRANCH: begin
          valid_d = 1'b0;
          if (bus.branch_taken) address_d = {8'd0, ir_q[23:16]};
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.address     = address_q;
  assign bus.valid       = valid_q;
  assign bus.operation   = ir_q[27:24];
  assign bus.destination = ir_q[23:16];
  assign bus.source1     = ir_q[15:8];
  assign bus.source0     = ir_q[7:0];
  assign bus.immediate   = ir_q[15:0];
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: an instruction-level program model
// predicts each active edge's outputs; a monitor compares 1 time unit after it.
module tb_instruction_fetch;
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_BLE = 4'd3;
  localparam logic [3:0] OP_STO = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd6;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [27:0] ir;
    logic [15:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();
  instruction_fetch_if wbus ();

  logic [27:0] rom [256];
  assign bus.instruction  = rom[bus.address[7:0]];
  assign wbus.instruction = rom[wbus.address[7:0]];
  assign wbus.stall        = 1'b0;
  assign wbus.branch_taken = 1'b0;

  instruction_fetch #(.PC_RESET(16'd0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  instruction_fetch #(.PC_RESET(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .bus(wbus)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Program-level reference model: address after each edge and what is shown.
  logic [15:0] m_addr, m_pc;
  logic [27:0] m_ir;
  logic        m_valid, m_ble;
  logic [7:0]  m_tgt;
  int          m_bubbles;

  task automatic model_reset();
    m_addr = 16'd0; m_pc = 16'd0; m_ir = 28'd0; m_valid = 1'b0;
    m_ble = 1'b0; m_tgt = 8'd0; m_bubbles = 0;
  endtask

  task automatic model_step(input logic s, input logic b);
    logic [27:0] ins;
    if (!s) begin
      if (m_bubbles > 0) begin
        m_bubbles--;
        m_valid = 1'b0;
        if (m_ble) begin
          if (b) m_addr = {8'd0, m_tgt};
          m_ble = 1'b0;
        end
      end else begin
        ins = rom[m_addr[7:0]];
        m_ir = ins; m_pc = m_addr; m_valid = 1'b1;
        if (ins[27:24] == OP_JMP) m_addr = {8'd0, ins[23:16]};
        else begin
          m_addr = m_addr + 16'd1;
          if (ins[27:24] == OP_NOP) m_bubbles = int'(ins[23:0]);
          else if (ins[27:24] == OP_BLE) begin
            m_bubbles = 1; m_ble = 1'b1; m_tgt = ins[23:16];
          end
        end
      end
    end
    exp_q.push_back('{valid: m_valid, pc: m_pc, ir: m_ir, addr: m_addr});
  endtask

  // Driver sits at posedge+2; sets inputs for the coming edge.
  task automatic step(input logic s, input logic b);
    bus.stall = s;
    bus.branch_taken = b;
    model_step(s, b);
    @(posedge clk);
    #2;
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("valid", 64'(bus.valid), 64'(mon_e.valid));
      check("address", 64'(bus.address), 64'(mon_e.addr));
      check("pc", 64'(bus.pc), 64'(mon_e.pc));
      check("fields", {20'd0, bus.operation, bus.destination, bus.source1, bus.source0, bus.immediate},
            {20'd0, mon_e.ir[27:24], mon_e.ir[23:16], mon_e.ir[15:8], mon_e.ir[7:0], mon_e.ir[15:0]});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    exp_q.delete();
    #1;
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_address", 64'(bus.address), 64'd0);
    check("rst_pc", 64'(bus.pc), 64'd0);
    check("rst_fields", {20'd0, bus.operation, bus.destination, bus.source1, bus.source0, bus.immediate}, 64'd0);
    check("rst_wrap_address", 64'(wbus.address), 64'hFFFE);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic fill_sto();
    for (int i = 0; i < 256; i++) rom[i] = {OP_STO, 8'd3, 16'h1129};
  endtask

  task automatic fill_random();
    logic [3:0] pass_ops [7];
    pass_ops = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9};
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 9))
        0:       rom[i] = {OP_NOP, 24'($urandom_range(0, 3))};
        1:       rom[i] = {OP_JMP, 8'($urandom), 16'($urandom)};
        2, 3:    rom[i] = {OP_BLE, 8'($urandom), 16'($urandom)};
        default: rom[i] = {pass_ops[$urandom_range(0, 6)], 24'($urandom)};
      endcase
    end
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    fill_sto();
    model_reset();
    @(posedge clk);
    #2;

    // Linear program
    do_reset();
    repeat (6) step(1'b0, 1'b0);

    // JMP without bubble
    fill_sto();
    rom[1] = {OP_JMP, 8'd5, 16'd0};
    do_reset();
    repeat (6) step(1'b0, 1'($urandom_range(0, 1)));

    // NOP delay of 3
    fill_sto();
    rom[0] = {OP_NOP, 24'd3};
    do_reset();
    repeat (8) step(1'b0, 1'($urandom_range(0, 1)));

    // BLE taken, then not taken
    fill_sto();
    rom[2] = {OP_BLE, 8'd8, 8'd1, 8'd2};
    do_reset();
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    do_reset();
    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1);

    // BLE held under stall, resolved taken on release
    do_reset();
    repeat (3) step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);

    // Reset mid-BRANCH with a taken condition pending
    do_reset();
    repeat (3) step(1'b0, 1'b0);
    bus.branch_taken = 1'b1;
    do_reset();
    repeat (3) step(1'b0, 1'b0);

    // Reset mid-WAIT of a long NOP
    fill_sto();
    rom[0] = {OP_NOP, 24'd4000};
    do_reset();
    repeat (10) step(1'b0, 1'b0);
    do_reset();
    repeat (3) step(1'b0, 1'b0);

    // Random programs with random stall and branch condition
    for (int r = 0; r < 3; r++) begin
      fill_random();
      do_reset();
      repeat (300) step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    // PC wrap at 16'hFFFF on the instance reset to 16'hFFFE
    fill_sto();
    do_reset();
    step(1'b0, 1'b0);
    check("wrap_address0", 64'(wbus.address), 64'hFFFF);
    check("wrap_pc0", 64'(wbus.pc), 64'hFFFE);
    check("wrap_valid0", 64'(wbus.valid), 64'd1);
    step(1'b0, 1'b0);
    check("wrap_address1", 64'(wbus.address), 64'h0000);
    check("wrap_pc1", 64'(wbus.pc), 64'hFFFF);
    step(1'b0, 1'b0);
    check("wrap_address2", 64'(wbus.address), 64'h0001);
    check("wrap_pc2", 64'(wbus.pc), 64'h0000);
    step(1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
